// File: rtl/key_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } key_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEF_LONG_CYC     = 100_000_000;
    localparam logic        KEY_ACTIVE       = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is configurable.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton into a level plus press/release strobes.
// Define KEY_LONG_PRESS_EN to enable the key_long hold-time strobe.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned CNT_W        = 27
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    if (CLK_FREQ_HZ == 0 || DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC ||
        CNT_W < $clog2(LONG_CYC + 1)) begin : g_bad_param
        $error("key_debounce: illegal parameter combination");
    end

    logic w_key_sync;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (key_in),
        .o_q   (w_key_sync)
    );

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             w_active;
    logic             w_cnt_done;

    assign w_active   = (w_key_sync == KEY_ACTIVE);
    assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Every state change clears cnt, so a bounce restarts qualification from zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_active) begin
                    w_state_nxt = DEB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            DEB_PRESS: begin
                if (!w_active) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_active) begin
                    w_state_nxt = DEB_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            DEB_RELEASE: begin
                if (w_active) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt   = RELEASED;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

`ifdef KEY_LONG_PRESS_EN
    logic [CNT_W-1:0] r_lcnt;
    logic             r_long;
    logic             r_long_done;
    logic             w_held;
    logic             w_lcnt_top;

    assign w_held     = (r_state == PRESSED) || (r_state == DEB_RELEASE);
    assign w_lcnt_top = (r_lcnt == CNT_W'(LONG_CYC - 1));

    // lcnt saturates, so r_long_done is what limits key_long to one pulse per press.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_lcnt      <= '0;
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
        end else if (w_press_nxt) begin
            r_lcnt      <= '0;
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
        end else begin
            r_long <= w_held && w_lcnt_top && !r_long_done;
            if (w_held && w_lcnt_top) begin
                r_long_done <= 1'b1;
            end
            if (w_held && !w_lcnt_top) begin
                r_lcnt <= r_lcnt + 1'b1;
            end
        end
    end

    assign key_long = r_long;
`else
    assign key_long = 1'b0;
`endif

endmodule
